echo_request_input: RTL and testbench

Portal request demarshaller for the Echo design: it accepts 32-bit request words written by the host into the portal request pipe, decodes the header, and reassembles the payload. Each complete message is issued as one method invocation (`say` or `say2`) toward the Echo core's `__ENA`/`__RDY` request ports. It is the host-to-hardware counterpart of the indication output portal. A small decoupling queue sits between word reassembly and method issue.

---
 rtl/echo_request_input.sv | 155 +++++++++++++++
 tb/tb_echo_request_input.sv | 202 ++++++++++++++++++++
 2 files changed

// File: rtl/echo_request_input.sv
// Echo portal request demarshaller: reassembles host words into
// say/say2 invocations through a small in-order decoupling queue.
module echo_request_input #(
  parameter int DEPTH = 2
) (
  input  logic        CLK,
  input  logic        RST_N,
  input  logic        EN_requests_0_enq,
  input  logic [31:0] requests_0_enq_v,
  output logic        RDY_requests_0_enq,
  output logic        RDY_messageSize_size,
  input  logic [15:0] messageSize_size_methodNumber,
  output logic [15:0] messageSize_size,
  output logic        say__ENA,
  output logic [31:0] say_v,
  input  logic        say__RDY,
  output logic        say2__ENA,
  output logic [15:0] say2_a,
  output logic [15:0] say2_b,
  input  logic        say2__RDY,
  output logic [15:0] err_count,
  output logic [15:0] err_last_id
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  typedef enum logic [1:0] {IDLE, COLLECT, DRAIN} state_t;

  state_t      state, state_nxt;
  logic [15:0] rem, rem_nxt;
  logic        sel, sel_nxt;
  logic [31:0] w1, w1_nxt;
  logic [15:0] w2, w2_nxt;
  logic        push, pop, err_hit, known;
  logic [15:0] hid, hlen;

  logic          q_sel [DEPTH];
  logic [31:0]   q_w1  [DEPTH];
  logic [15:0]   q_w2  [DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [CW-1:0] count, count_nxt;
  logic          full, head_v;

  assign hid   = requests_0_enq_v[31:16];
  assign hlen  = requests_0_enq_v[15:0];
  assign known = (hid == 16'd0 && hlen == 16'd2) ||
                 (hid == 16'd1 && hlen == 16'd3);

  always_comb begin
    state_nxt = state;
    rem_nxt   = rem;
    sel_nxt   = sel;
    w1_nxt    = w1;
    w2_nxt    = w2;
    push      = 1'b0;
    err_hit   = 1'b0;
    if (EN_requests_0_enq) begin
      unique case (state)
        IDLE: begin
          if (known) begin
            state_nxt = COLLECT;
            rem_nxt   = hlen - 16'd1;
            sel_nxt   = hid[0];
          end else begin
            err_hit = 1'b1;
            if (hlen >= 16'd2) begin
              state_nxt = DRAIN;
              rem_nxt   = hlen - 16'd1;
            end
          end
        end
        COLLECT: begin
          // say2 takes a in the first payload word, b in the second
          if (!sel || rem == 16'd2) w1_nxt = requests_0_enq_v;
          else w2_nxt = requests_0_enq_v[15:0];
          if (rem != 16'd0) rem_nxt = rem - 16'd1;
          if (rem <= 16'd1) begin
            push      = 1'b1;
            state_nxt = IDLE;
          end
        end
        DRAIN: begin
          if (rem != 16'd0) rem_nxt = rem - 16'd1;
          if (rem <= 16'd1) state_nxt = IDLE;
        end
        default: state_nxt = IDLE;
      endcase
    end
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state       <= IDLE;
      rem         <= '0;
      sel         <= 1'b0;
      w1          <= '0;
      w2          <= '0;
      err_count   <= '0;
      err_last_id <= '0;
    end else begin
      state <= state_nxt;
      rem   <= rem_nxt;
      sel   <= sel_nxt;
      w1    <= w1_nxt;
      w2    <= w2_nxt;
      if (err_hit) begin
        if (err_count != 16'hFFFF) err_count <= err_count + 16'd1;
        err_last_id <= hid;
      end
    end
  end

  assign head_v    = count != '0;
  assign say__ENA  = head_v && !q_sel[rd_ptr] && say__RDY;
  assign say2__ENA = head_v && q_sel[rd_ptr] && say2__RDY;
  assign pop       = say__ENA | say2__ENA;
  assign count_nxt = count + CW'(push) - CW'(pop);

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      full   <= 1'b0;
    end else begin
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop) rd_ptr <= rd_ptr + AW'(1);
      count <= count_nxt;
      full  <= count_nxt == CW'(DEPTH);
    end
  end

  always_ff @(posedge CLK) begin
    if (push) begin
      q_sel[wr_ptr] <= sel;
      q_w1[wr_ptr]  <= w1_nxt;
      q_w2[wr_ptr]  <= w2_nxt;
    end
  end

  assign say_v  = q_w1[rd_ptr];
  assign say2_a = q_w1[rd_ptr][15:0];
  assign say2_b = q_w2[rd_ptr];

  // only the queue-filling final payload word can ever stall the host
  assign RDY_requests_0_enq =
    !(state == COLLECT && rem == 16'd1 && full);
  assign RDY_messageSize_size = 1'b1;

  always_comb begin
    messageSize_size = 16'd0;
    if (messageSize_size_methodNumber == 16'd0) messageSize_size = 16'd2;
    else if (messageSize_size_methodNumber == 16'd1) messageSize_size = 16'd3;
  end
endmodule

// File: tb/tb_echo_request_input.sv
// Directed bench for echo_request_input: decode, queueing,
// backpressure, error drop and mid-message reset.
module tb_echo_request_input;
  logic        clk = 1'b0;
  logic        rst_n;
  logic        en;
  logic [31:0] v;
  logic        rdy;
  logic        rdy_ms;
  logic [15:0] mnum;
  logic [15:0] msize;
  logic        say_ena;
  logic [31:0] say_v;
  logic        say_rdy;
  logic        say2_ena;
  logic [15:0] say2_a;
  logic [15:0] say2_b;
  logic        say2_rdy;
  logic [15:0] err_count;
  logic [15:0] err_last_id;

  int compared = 0;
  int mismatched = 0;

  always #5 clk = ~clk;

  echo_request_input #(.DEPTH(2)) dut (
    .CLK(clk),
    .RST_N(rst_n),
    .EN_requests_0_enq(en),
    .requests_0_enq_v(v),
    .RDY_requests_0_enq(rdy),
    .RDY_messageSize_size(rdy_ms),
    .messageSize_size_methodNumber(mnum),
    .messageSize_size(msize),
    .say__ENA(say_ena),
    .say_v(say_v),
    .say__RDY(say_rdy),
    .say2__ENA(say2_ena),
    .say2_a(say2_a),
    .say2_b(say2_b),
    .say2__RDY(say2_rdy),
    .err_count(err_count),
    .err_last_id(err_last_id)
  );

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // drive one cycle, then settle just past the rising edge
  task automatic step(input logic e, input logic [31:0] w);
    en = e;
    v  = w;
    @(posedge clk);
    #1;
    en = 1'b0;
  endtask

  initial begin
    rst_n = 1'b0;
    en = 1'b0;
    v = '0;
    mnum = '0;
    say_rdy = 1'b0;
    say2_rdy = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_say_ena", 32'(say_ena), 32'd0);
    chk("rst_say2_ena", 32'(say2_ena), 32'd0);
    chk("rst_err_count", 32'(err_count), 32'd0);
    chk("rst_err_last", 32'(err_last_id), 32'd0);
    chk("rst_rdy", 32'(rdy), 32'd1);
    chk("rdy_ms", 32'(rdy_ms), 32'd1);
    rst_n = 1'b1;
    step(1'b0, 32'd0);

    // single say
    say_rdy = 1'b1;
    step(1'b1, 32'h0000_0002);
    chk("say_hdr_noena", 32'(say_ena), 32'd0);
    step(1'b1, 32'hDEAD_BEEF);
    chk("say_ena", 32'(say_ena), 32'd1);
    chk("say_v", say_v, 32'hDEAD_BEEF);
    step(1'b0, 32'd0);
    chk("say_once", 32'(say_ena), 32'd0);

    // single say2
    say2_rdy = 1'b1;
    step(1'b1, 32'h0001_0003);
    step(1'b1, 32'hFFFF_1234);
    chk("say2_mid_noena", 32'(say2_ena), 32'd0);
    step(1'b1, 32'h0000_5678);
    chk("say2_ena", 32'(say2_ena), 32'd1);
    chk("say2_a", 32'(say2_a), 32'h1234);
    chk("say2_b", 32'(say2_b), 32'h5678);
    chk("say2_no_say", 32'(say_ena), 32'd0);
    step(1'b0, 32'd0);
    chk("say2_once", 32'(say2_ena), 32'd0);

    // backpressure with core stalled
    say_rdy = 1'b0;
    step(1'b1, 32'h0000_0002);
    step(1'b1, 32'h1111_1111);
    step(1'b1, 32'h0000_0002);
    step(1'b1, 32'h2222_2222);
    chk("bp_hdr_rdy", 32'(rdy), 32'd1);
    step(1'b1, 32'h0000_0002);
    chk("bp_rdy_low", 32'(rdy), 32'd0);
    chk("bp_no_ena", 32'(say_ena), 32'd0);
    step(1'b0, 32'd0);
    chk("bp_rdy_held", 32'(rdy), 32'd0);
    say_rdy = 1'b1;
    #1;
    chk("bp_ena1", 32'(say_ena), 32'd1);
    chk("bp_v1", say_v, 32'h1111_1111);
    chk("bp_rdy_still_low", 32'(rdy), 32'd0);
    step(1'b0, 32'd0);
    chk("bp_rdy_back", 32'(rdy), 32'd1);
    chk("bp_ena2", 32'(say_ena), 32'd1);
    chk("bp_v2", say_v, 32'h2222_2222);
    step(1'b1, 32'h3333_3333);
    chk("bp_ena3", 32'(say_ena), 32'd1);
    chk("bp_v3", say_v, 32'h3333_3333);
    step(1'b0, 32'd0);
    chk("bp_drained", 32'(say_ena), 32'd0);

    // unknown id, drained
    step(1'b1, 32'h0007_0004);
    chk("unk_err_count", 32'(err_count), 32'd1);
    chk("unk_err_id", 32'(err_last_id), 32'd7);
    step(1'b1, 32'h0000_0002);
    step(1'b1, 32'hAAAA_AAAA);
    step(1'b1, 32'h0001_0003);
    chk("unk_dropped", 32'(say_ena | say2_ena), 32'd0);
    step(1'b1, 32'h0000_0002);
    step(1'b1, 32'hCAFE_F00D);
    chk("unk_after_ena", 32'(say_ena), 32'd1);
    chk("unk_after_v", say_v, 32'hCAFE_F00D);
    chk("unk_err_hold", 32'(err_count), 32'd1);
    step(1'b0, 32'd0);

    // say with wrong length
    step(1'b1, 32'h0000_0003);
    chk("badlen_err_count", 32'(err_count), 32'd2);
    chk("badlen_err_id", 32'(err_last_id), 32'd0);
    step(1'b1, 32'h0000_0002);
    step(1'b1, 32'h1234_5678);
    chk("badlen_dropped", 32'(say_ena | say2_ena), 32'd0);

    // length <= 1 stays in IDLE
    step(1'b1, 32'h0009_0001);
    chk("short_err_count", 32'(err_count), 32'd3);
    chk("short_err_id", 32'(err_last_id), 32'd9);
    step(1'b1, 32'h0000_0002);
    step(1'b1, 32'h0BAD_F00D);
    chk("short_after_ena", 32'(say_ena), 32'd1);
    chk("short_after_v", say_v, 32'h0BAD_F00D);
    step(1'b0, 32'd0);

    // message size queries
    mnum = 16'd0;
    #1;
    chk("size_0", 32'(msize), 32'd2);
    mnum = 16'd1;
    #1;
    chk("size_1", 32'(msize), 32'd3);
    mnum = 16'd5;
    #1;
    chk("size_5", 32'(msize), 32'd0);

    // reset mid-message
    step(1'b1, 32'h0001_0003);
    rst_n = 1'b0;
    #2;
    chk("mrst_err", 32'(err_count), 32'd0);
    @(posedge clk);
    #3;
    rst_n = 1'b1;
    #1;
    chk("mrst_say2_ena", 32'(say2_ena), 32'd0);
    chk("mrst_say_ena", 32'(say_ena), 32'd0);
    chk("mrst_rdy", 32'(rdy), 32'd1);
    step(1'b1, 32'h0000_0002);
    chk("mrst_hdr_noena", 32'(say_ena), 32'd0);
    step(1'b1, 32'h55AA_55AA);
    chk("mrst_say_ena2", 32'(say_ena), 32'd1);
    chk("mrst_say_v", say_v, 32'h55AA_55AA);
    chk("mrst_no_err", 32'(err_count), 32'd0);
    step(1'b0, 32'd0);
    chk("mrst_done", 32'(say_ena | say2_ena), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             compared, mismatched);
    $finish;
  end
endmodule
